writer: RTL
===========

Name: writer

Overview:
- Avalon-MM write master that stores one block of NDWORDS 32-bit words to memory at byte address baseaddr + index*4*NDWORDS.
- Each block is written as 2*NDWORDS halfword beats over a 16-bit data bus.
- It is the store-side counterpart of the block reader and uses the same block addressing, so a block written at (baseaddr, index) reads back unchanged.
- Front end is a request/ready handshake with a one-deep pending slot, so consecutive blocks are written with no bubble between them.

Parameters:
- NDWORDS, 1, 32-bit words per block (must be >= 1); block width BLOCKSZ = 32*NDWORDS.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- baseaddr  in  32  byte base address of the block array.
- index  in  32  block index.
- write  in  1  request strobe; accepted on a rising edge when write && ready.
- data  in  BLOCKSZ  block payload; halfword k = data[16k+15:16k].
- ready  out  1  request can be accepted this cycle.
- done  out  1  one-cycle pulse per completed block.
- avm_m0_write  out  1  Avalon write request.
- avm_m0_address  out  32  byte address of the current beat.
- avm_m0_writedata  out  16  halfword of the current beat.
- avm_m0_byteenable  out  2  constant 2'b11.
- avm_m0_waitrequest  in  1  slave stall.

Behaviour:
- Reset values: avm_m0_write=0, avm_m0_address=0, avm_m0_writedata=0, done=0, pending slot empty, state IDLE. ready is driven from registers and reads 1 during and after reset.
- Reset assertion is asynchronous and has immediate effect:
  - avm_m0_write drops in the same cycle.
  - The in-flight block and any pending block are discarded.
  - No done is issued for discarded blocks.
- ready = !pend_valid. ready does not depend combinationally on write or waitrequest.
- Captured at accept:
  - addr0 = baseaddr + index*(4*NDWORDS), arithmetic modulo 2^32.
  - The full data word.
- Beat k, for k = 0 .. 2*NDWORDS-1:
  - address = addr0 + 2k, modulo 2^32 (wraps past 0xFFFFFFFF).
  - writedata = data[16k+15:16k], low halfword first.
- States:
  - IDLE: avm_m0_write=0. On accept, load the active block and go to WRITE. First beat appears the cycle after accept.
  - WRITE: avm_m0_write=1, with address/writedata taken from the active block and beat counter.
- Beat acceptance:
  - A beat is accepted on a rising edge with avm_m0_waitrequest=0.
  - While waitrequest=1, address, writedata and write are held stable.
  - An accepted non-final beat increments the counter; the next beat appears the following cycle.
- Accept while in WRITE: the request goes to the pending slot (pend_valid=1) and ready falls the next cycle.
- On acceptance of the final beat, checked in this priority:
  1. pend_valid=1: pending moves to active, counter resets to 0, stay in WRITE. Next cycle carries beat 0 of the new block, so there is no idle cycle. pend_valid clears.
  2. Else, a request accepted in this same cycle: load it directly into active and stay in WRITE.
  3. Else: go to IDLE.
- done is registered and is 1 for exactly the cycle after each final-beat acceptance.
- A request arriving while ready=0 is ignored. The requester must hold write until it sees ready.
- Only the accepted capture matters: index, data and baseaddr may change freely after acceptance.
- Ordering: blocks are written strictly in acceptance order, and beats in ascending address order.

Test Plan:
1. Reset check: hold reset=0 for 4 cycles, then release. Required: write=0, done=0, ready=1 throughout. Then assert reset=0 asynchronously mid-cycle during an idle period; outputs must stay at reset values.
2. Single block, NDWORDS=1, baseaddr=0, index=0, data=0x000B000A, waitrequest=0. Required:
   - Cycle after accept: write=1, address=0x0, writedata=0x000A.
   - Next cycle: address=0x2, writedata=0x000B.
   - Next cycle: write=0 and done=1 for one cycle.
3. Stall: same as test 2 with waitrequest=1 for 3 cycles on beat 0. Required: address 0x0 and data 0x000A held stable for 4 cycles; beat 1 follows; exactly 2 accepted beats; one done pulse.
4. Back-to-back: index=1 with data=0x00020001, then index=2 with data=0x00040003 on the next cycle, then a third request (index=3) held while ready=0. Required:
   - Continuous write=1 across beats at addresses 0x4, 0x6, 0x8, 0xA carrying 0001, 0002, 0003, 0004.
   - ready=0 while the pending slot is full.
   - Third block accepted on the cycle ready rises and written at addresses 0xC and 0xE.
   - done pulses once per block.
5. Wrap: baseaddr=0xFFFFFFFC. Required: index=0 writes addresses 0xFFFFFFFC, 0xFFFFFFFE; index=1 writes 0x00000000, 0x00000002. Repeat with NDWORDS=2, index=3, baseaddr=0: beats at 0x18, 0x1A, 0x1C, 0x1E.
6. Reset mid-write: pending full and waitrequest=1, then drive reset=0. Required: write drops immediately; no done pulse; after release ready=1, and a new request writes correctly from beat 0.

Source files
------------

// File: rtl/writer.sv
// Avalon-MM write master: stores one NDWORDS x 32-bit block as 2*NDWORDS halfword beats
// at baseaddr + index*4*NDWORDS, with a one-deep pending slot for gap-free streaming.
module writer #(
    parameter int NDWORDS = 1,
    localparam int BLOCKSZ = 32 * NDWORDS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        baseaddr,
    input  logic [31:0]        index,
    input  logic               write,
    input  logic [BLOCKSZ-1:0] data,
    output logic               ready,
    output logic               done,
    output logic               avm_m0_write,
    output logic [31:0]        avm_m0_address,
    output logic [15:0]        avm_m0_writedata,
    output logic [1:0]         avm_m0_byteenable,
    input  logic               avm_m0_waitrequest
);

    localparam int          NBEATS      = 2 * NDWORDS;
    localparam int          CNT_W       = $clog2(NBEATS);
    localparam logic [31:0] BLOCK_BYTES = 32'(4 * NDWORDS);

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   beat_cnt;
    logic [BLOCKSZ-1:0] act_rest;     // halfwords not yet presented, next one in [15:0]
    logic               pend_valid;
    logic [31:0]        pend_addr;
    logic [BLOCKSZ-1:0] pend_data;

    logic               accept;
    logic               beat_ack;
    logic               last_beat;
    logic               load;
    logic [31:0]        load_addr;
    logic [BLOCKSZ-1:0] load_data;

    assign ready             = !pend_valid;
    assign avm_m0_byteenable = 2'b11;

    assign accept    = write && ready;
    assign beat_ack  = (state == WRITE) && !avm_m0_waitrequest;
    assign last_beat = (beat_cnt == CNT_W'(NBEATS - 1));

    // A new active block starts from idle, or straight off a final beat when a
    // block is waiting (pending first, otherwise a request arriving this cycle).
    assign load = ((state == IDLE) && accept) ||
                  (beat_ack && last_beat && (pend_valid || accept));

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        load_addr = baseaddr + index * BLOCK_BYTES;
        load_data = data;
        if (pend_valid) begin
            load_addr = pend_addr;
            load_data = pend_data;
        end
    end

    // NOTE: state registers use non-blocking assignments only; the data holding registers
    // are reset as well so a discarded block never leaks onto the bus after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            beat_cnt         <= '0;
            act_rest         <= '0;
            pend_valid       <= 1'b0;
            pend_addr        <= '0;
            pend_data        <= '0;
            done             <= 1'b0;
            avm_m0_write     <= 1'b0;
            avm_m0_address   <= '0;
            avm_m0_writedata <= '0;
        end else begin
            done <= beat_ack && last_beat;

            if (load) begin
                state            <= WRITE;
                beat_cnt         <= '0;
                avm_m0_write     <= 1'b1;
                avm_m0_address   <= load_addr;
                avm_m0_writedata <= load_data[15:0];
                act_rest         <= load_data >> 16;
            end else if (beat_ack && last_beat) begin
                state        <= IDLE;
                avm_m0_write <= 1'b0;
            end else if (beat_ack) begin
                beat_cnt         <= beat_cnt + CNT_W'(1);
                avm_m0_address   <= avm_m0_address + 32'd2;
                avm_m0_writedata <= act_rest[15:0];
                act_rest         <= act_rest >> 16;
            end

            // The pending slot drains when the active block finishes, and fills
            // from a request accepted mid-block.
            if (pend_valid && beat_ack && last_beat) begin
                pend_valid <= 1'b0;
            end else if (accept && (state == WRITE) && !(beat_ack && last_beat)) begin
                pend_valid <= 1'b1;
                pend_addr  <= load_addr;
                pend_data  <= data;
            end
        end
    end

endmodule
